// File: rtl/axi_arb_pkg.sv
// ----------------------------------------------------------------------------
// axi_arb_pkg
// Shared definitions for the two-master AXI read arbiter:
//   ar_state_e : AR channel FSM encoding (IDLE = no slave AR in flight,
//                PEND = slave AR register valid and waiting for arready)
//   M0_IDX/M1_IDX : master index values, also the MSB of the slave-side ID
// ----------------------------------------------------------------------------
package axi_arb_pkg;

   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_PEND = 1'b1
   } ar_state_e;

   localparam logic M0_IDX = 1'b0;
   localparam logic M1_IDX = 1'b1;

endpackage : axi_arb_pkg

// File: rtl/axi_arb_outcnt.sv
// ----------------------------------------------------------------------------
// axi_arb_outcnt
// Outstanding read-burst counter for one master.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   inc        : slave AR handshake for this master
//   beat       : slave R handshake routed to this master
//   last       : rlast of that beat
//   full       : count has reached MAX_OUT (blocks further grants)
//   underflow  : a beat arrived while nothing is outstanding
// ----------------------------------------------------------------------------
module axi_arb_outcnt #(
   parameter int  MAX_OUT = 4,
   localparam int CW      = $clog2(MAX_OUT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic beat,
   input  logic last,
   output logic full,
   output logic underflow
);

   localparam logic [CW-1:0] CNT_ONE  = CW'(32'd1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUT);
   localparam logic [CW-1:0] CNT_ZERO = CW'(32'd0);

   logic [CW-1:0] count_r;
   logic          empty_s;
   logic          inc_s;
   logic          dec_s;

   // Qualify inc/dec so the count saturates at both ends.
   always_comb begin
      empty_s   = (count_r == CNT_ZERO);
      full      = (count_r == CNT_MAX);
      inc_s     = inc & ~full;
      dec_s     = beat & last & ~empty_s;
      underflow = beat & empty_s;
   end

   // Outstanding count register; simultaneous inc and dec cancel.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= CNT_ZERO;
      end else begin
         case ({inc_s, dec_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule : axi_arb_outcnt

// File: rtl/axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// axi_rd_arbiter
// Two-master to one-slave AXI read arbiter.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   i_mN_ar* / o_mN_arready      : master N read-address channel (N = 0,1)
//   o_mN_r*  / i_mN_rready       : master N read-data channel
//   o_s_ar*  / i_s_arready       : slave read-address channel (ID MSB = master)
//   i_s_r*   / o_s_rready        : slave read-data channel
//   o_err                        : sticky, R beat for a master with nothing
//                                  outstanding
// AR requests are granted round-robin from IDLE into a registered slave AR
// slot; R beats are steered combinationally by the slave ID MSB.
// ----------------------------------------------------------------------------
module axi_rd_arbiter
   import axi_arb_pkg::*;
#(
   parameter int ID_WIDTH = 4,
   parameter int MAX_OUT  = 4
) (
   input  logic                clk,
   input  logic                rst,
   // master 0
   input  logic                i_m0_arvalid,
   output logic                o_m0_arready,
   input  logic [ID_WIDTH-1:0] i_m0_arid,
   input  logic [31:0]         i_m0_araddr,
   input  logic [7:0]          i_m0_arlen,
   input  logic [2:0]          i_m0_arsize,
   input  logic [1:0]          i_m0_arburst,
   output logic                o_m0_rvalid,
   input  logic                i_m0_rready,
   output logic [ID_WIDTH-1:0] o_m0_rid,
   output logic [63:0]         o_m0_rdata,
   output logic [1:0]          o_m0_rresp,
   output logic                o_m0_rlast,
   // master 1
   input  logic                i_m1_arvalid,
   output logic                o_m1_arready,
   input  logic [ID_WIDTH-1:0] i_m1_arid,
   input  logic [31:0]         i_m1_araddr,
   input  logic [7:0]          i_m1_arlen,
   input  logic [2:0]          i_m1_arsize,
   input  logic [1:0]          i_m1_arburst,
   output logic                o_m1_rvalid,
   input  logic                i_m1_rready,
   output logic [ID_WIDTH-1:0] o_m1_rid,
   output logic [63:0]         o_m1_rdata,
   output logic [1:0]          o_m1_rresp,
   output logic                o_m1_rlast,
   // slave
   output logic                o_s_arvalid,
   input  logic                i_s_arready,
   output logic [ID_WIDTH:0]   o_s_arid,
   output logic [31:0]         o_s_araddr,
   output logic [7:0]          o_s_arlen,
   output logic [2:0]          o_s_arsize,
   output logic [1:0]          o_s_arburst,
   input  logic                i_s_rvalid,
   output logic                o_s_rready,
   input  logic [ID_WIDTH:0]   i_s_rid,
   input  logic [63:0]         i_s_rdata,
   input  logic [1:0]          i_s_rresp,
   input  logic                i_s_rlast,
   // status
   output logic                o_err
);

   ar_state_e         state_r;
   ar_state_e         state_nxt_s;
   logic              prio_r;        // master index preferred on a tie
   logic              grant_v_s;
   logic              grant_idx_s;
   logic              elig0_s;
   logic              elig1_s;
   logic              full0_s;
   logic              full1_s;
   logic              uf0_s;
   logic              uf1_s;
   logic              ar_hs_s;
   logic              r_sel_s;
   logic              r_hs0_s;
   logic              r_hs1_s;
   logic              err_r;
   logic [ID_WIDTH:0] s_arid_r;
   logic [31:0]       s_araddr_r;
   logic [7:0]        s_arlen_r;
   logic [2:0]        s_arsize_r;
   logic [1:0]        s_arburst_r;

   // Eligibility, round-robin pick and AR FSM next state.
   always_comb begin
      elig0_s     = i_m0_arvalid & ~full0_s;
      elig1_s     = i_m1_arvalid & ~full1_s;
      grant_v_s   = 1'b0;
      grant_idx_s = M0_IDX;
      state_nxt_s = state_r;
      case (state_r)
         AR_IDLE: begin
            if (elig0_s | elig1_s) begin
               grant_v_s   = 1'b1;
               state_nxt_s = AR_PEND;
               if (elig0_s & elig1_s) begin
                  grant_idx_s = prio_r;
               end else if (elig1_s) begin
                  grant_idx_s = M1_IDX;
               end else begin
                  grant_idx_s = M0_IDX;
               end
            end else begin
               state_nxt_s = AR_IDLE;
            end
         end
         AR_PEND: begin
            if (i_s_arready) begin
               state_nxt_s = AR_IDLE;
            end else begin
               state_nxt_s = AR_PEND;
            end
         end
         default: state_nxt_s = AR_IDLE;
      endcase
      // arready is a same-cycle acknowledgement of the grant; held low in reset
      o_m0_arready = grant_v_s & (grant_idx_s == M0_IDX) & ~rst;
      o_m1_arready = grant_v_s & (grant_idx_s == M1_IDX) & ~rst;
      ar_hs_s      = (state_r == AR_PEND) & i_s_arready;
   end

   // AR FSM state, round-robin pointer and slave AR register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= AR_IDLE;
         prio_r      <= M0_IDX;
         s_arid_r    <= {(ID_WIDTH+1){1'b0}};
         s_araddr_r  <= 32'd0;
         s_arlen_r   <= 8'd0;
         s_arsize_r  <= 3'd0;
         s_arburst_r <= 2'd0;
      end else begin
         state_r <= state_nxt_s;
         if (grant_v_s) begin
            prio_r <= ~grant_idx_s;
            if (grant_idx_s == M1_IDX) begin
               s_arid_r    <= {M1_IDX, i_m1_arid};
               s_araddr_r  <= i_m1_araddr;
               s_arlen_r   <= i_m1_arlen;
               s_arsize_r  <= i_m1_arsize;
               s_arburst_r <= i_m1_arburst;
            end else begin
               s_arid_r    <= {M0_IDX, i_m0_arid};
               s_araddr_r  <= i_m0_araddr;
               s_arlen_r   <= i_m0_arlen;
               s_arsize_r  <= i_m0_arsize;
               s_arburst_r <= i_m0_arburst;
            end
         end else begin
            prio_r <= prio_r;
         end
      end
   end

   assign o_s_arvalid = (state_r == AR_PEND);
   assign o_s_arid    = s_arid_r;
   assign o_s_araddr  = s_araddr_r;
   assign o_s_arlen   = s_arlen_r;
   assign o_s_arsize  = s_arsize_r;
   assign o_s_arburst = s_arburst_r;

   // R channel steering by the slave ID MSB, independent of the AR FSM.
   always_comb begin
      r_sel_s     = i_s_rid[ID_WIDTH];
      o_m0_rvalid = i_s_rvalid & (r_sel_s == M0_IDX);
      o_m1_rvalid = i_s_rvalid & (r_sel_s == M1_IDX);
      if (r_sel_s == M1_IDX) begin
         o_s_rready = i_m1_rready;
      end else begin
         o_s_rready = i_m0_rready;
      end
      r_hs0_s    = o_m0_rvalid & i_m0_rready;
      r_hs1_s    = o_m1_rvalid & i_m1_rready;
      o_m0_rid   = i_s_rid[ID_WIDTH-1:0];
      o_m1_rid   = i_s_rid[ID_WIDTH-1:0];
      o_m0_rdata = i_s_rdata;
      o_m1_rdata = i_s_rdata;
      o_m0_rresp = i_s_rresp;
      o_m1_rresp = i_s_rresp;
      o_m0_rlast = i_s_rlast;
      o_m1_rlast = i_s_rlast;
   end

   axi_arb_outcnt #(.MAX_OUT(MAX_OUT)) u_cnt_m0 (
      .clk       (clk),
      .rst       (rst),
      .inc       (ar_hs_s & (s_arid_r[ID_WIDTH] == M0_IDX)),
      .beat      (r_hs0_s),
      .last      (i_s_rlast),
      .full      (full0_s),
      .underflow (uf0_s)
   );

   axi_arb_outcnt #(.MAX_OUT(MAX_OUT)) u_cnt_m1 (
      .clk       (clk),
      .rst       (rst),
      .inc       (ar_hs_s & (s_arid_r[ID_WIDTH] == M1_IDX)),
      .beat      (r_hs1_s),
      .last      (i_s_rlast),
      .full      (full1_s),
      .underflow (uf1_s)
   );

   // Sticky underflow flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_r <= 1'b0;
      end else if (uf0_s | uf1_s) begin
         err_r <= 1'b1;
      end else begin
         err_r <= err_r;
      end
   end

   assign o_err = err_r;

endmodule : axi_rd_arbiter

// File: tb/tb_axi_rd_arbiter.sv
// ----------------------------------------------------------------------------
// tb_axi_rd_arbiter
// Directed self-checking bench for axi_rd_arbiter (ID_WIDTH=4, MAX_OUT=4).
// Inputs change just after the falling edge; outputs are checked #1 later,
// well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_axi_rd_arbiter;

   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_m0_arvalid, i_m1_arvalid;
   logic          o_m0_arready, o_m1_arready;
   logic [IW-1:0] i_m0_arid, i_m1_arid;
   logic [31:0]   i_m0_araddr, i_m1_araddr;
   logic [7:0]    i_m0_arlen, i_m1_arlen;
   logic [2:0]    i_m0_arsize, i_m1_arsize;
   logic [1:0]    i_m0_arburst, i_m1_arburst;
   logic          o_m0_rvalid, o_m1_rvalid;
   logic          i_m0_rready, i_m1_rready;
   logic [IW-1:0] o_m0_rid, o_m1_rid;
   logic [63:0]   o_m0_rdata, o_m1_rdata;
   logic [1:0]    o_m0_rresp, o_m1_rresp;
   logic          o_m0_rlast, o_m1_rlast;
   logic          o_s_arvalid, i_s_arready;
   logic [IW:0]   o_s_arid;
   logic [31:0]   o_s_araddr;
   logic [7:0]    o_s_arlen;
   logic [2:0]    o_s_arsize;
   logic [1:0]    o_s_arburst;
   logic          i_s_rvalid, o_s_rready;
   logic [IW:0]   i_s_rid;
   logic [63:0]   i_s_rdata;
   logic [1:0]    i_s_rresp;
   logic          i_s_rlast;
   logic          o_err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   axi_rd_arbiter #(.ID_WIDTH(IW), .MAX_OUT(4)) dut (
      .clk(clk), .rst(rst),
      .i_m0_arvalid(i_m0_arvalid), .o_m0_arready(o_m0_arready),
      .i_m0_arid(i_m0_arid), .i_m0_araddr(i_m0_araddr), .i_m0_arlen(i_m0_arlen),
      .i_m0_arsize(i_m0_arsize), .i_m0_arburst(i_m0_arburst),
      .o_m0_rvalid(o_m0_rvalid), .i_m0_rready(i_m0_rready), .o_m0_rid(o_m0_rid),
      .o_m0_rdata(o_m0_rdata), .o_m0_rresp(o_m0_rresp), .o_m0_rlast(o_m0_rlast),
      .i_m1_arvalid(i_m1_arvalid), .o_m1_arready(o_m1_arready),
      .i_m1_arid(i_m1_arid), .i_m1_araddr(i_m1_araddr), .i_m1_arlen(i_m1_arlen),
      .i_m1_arsize(i_m1_arsize), .i_m1_arburst(i_m1_arburst),
      .o_m1_rvalid(o_m1_rvalid), .i_m1_rready(i_m1_rready), .o_m1_rid(o_m1_rid),
      .o_m1_rdata(o_m1_rdata), .o_m1_rresp(o_m1_rresp), .o_m1_rlast(o_m1_rlast),
      .o_s_arvalid(o_s_arvalid), .i_s_arready(i_s_arready), .o_s_arid(o_s_arid),
      .o_s_araddr(o_s_araddr), .o_s_arlen(o_s_arlen), .o_s_arsize(o_s_arsize),
      .o_s_arburst(o_s_arburst),
      .i_s_rvalid(i_s_rvalid), .o_s_rready(o_s_rready), .i_s_rid(i_s_rid),
      .i_s_rdata(i_s_rdata), .i_s_rresp(i_s_rresp), .i_s_rlast(i_s_rlast),
      .o_err(o_err)
   );

   // One slave R beat for the given slave ID, held for one cycle.
   task automatic r_beat(input logic [IW:0] rid, input logic last);
      i_s_rid    = rid;
      i_s_rlast  = last;
      i_s_rvalid = 1'b1;
      @(negedge clk);
      i_s_rvalid = 1'b0;
      i_s_rlast  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_m0_arvalid = 1'b1;
      i_m1_arvalid = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (o_s_arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid got=%b exp=0", o_s_arvalid); end
      total++;
      if ({o_m0_arready, o_m1_arready} !== 2'b00) begin bad++; $display("FAIL rst_arready got=%b exp=00", {o_m0_arready, o_m1_arready}); end
      total++;
      if (o_err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", o_err); end
      total++;
      if ({o_s_arid, o_s_araddr, o_s_arlen} !== 45'd0) begin bad++; $display("FAIL rst_arreg got=%h exp=0", {o_s_arid, o_s_araddr, o_s_arlen}); end
      total++;
      if ({dut.u_cnt_m0.count_r, dut.u_cnt_m1.count_r} !== 6'd0) begin bad++; $display("FAIL rst_cnt got=%h exp=0", {dut.u_cnt_m0.count_r, dut.u_cnt_m1.count_r}); end
      i_m0_arvalid = 1'b0;
      i_m1_arvalid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Both masters request continuously: m0, m1, m0, m1, one AR per 2 cycles.
   task automatic test_round_robin();
      logic exp_idx;
      i_m0_arid = 4'h1; i_m0_araddr = 32'h0000_1000;
      i_m1_arid = 4'h2; i_m1_araddr = 32'h0000_2000;
      i_s_arready  = 1'b1;
      i_m0_arvalid = 1'b1;
      i_m1_arvalid = 1'b1;
      for (int g = 0; g < 4; g++) begin
         exp_idx = g[0];
         #1;
         total++;
         if ({o_m1_arready, o_m0_arready, o_s_arvalid} !== {exp_idx, ~exp_idx, 1'b0}) begin
            bad++; $display("FAIL rr_grant%0d got=%b exp=%b", g, {o_m1_arready, o_m0_arready, o_s_arvalid}, {exp_idx, ~exp_idx, 1'b0});
         end
         @(negedge clk); #1;
         total++;
         if ({o_s_arvalid, o_s_arid} !== {1'b1, exp_idx, (exp_idx ? 4'h2 : 4'h1)}) begin
            bad++; $display("FAIL rr_issue%0d got=%b_%h exp_idx=%b", g, o_s_arvalid, o_s_arid, exp_idx);
         end
         total++;
         if (o_s_araddr !== (exp_idx ? 32'h0000_2000 : 32'h0000_1000)) begin
            bad++; $display("FAIL rr_addr%0d got=%h", g, o_s_araddr);
         end
         @(negedge clk);
      end
      i_m0_arvalid = 1'b0;
      i_m1_arvalid = 1'b0;
      total++;
      if ({dut.u_cnt_m0.count_r, dut.u_cnt_m1.count_r} !== {3'd2, 3'd2}) begin bad++; $display("FAIL rr_cnt got=%h exp=22", {dut.u_cnt_m0.count_r, dut.u_cnt_m1.count_r}); end
      r_beat(5'h01, 1'b1); r_beat(5'h01, 1'b1);
      r_beat(5'h12, 1'b1); r_beat(5'h12, 1'b1);
   endtask

   // m0 fills to MAX_OUT, is blocked, then one rlast frees a slot.
   task automatic test_max_out();
      i_m0_arvalid = 1'b1;
      i_s_arready  = 1'b1;
      repeat (8) @(negedge clk);
      for (int c = 0; c < 3; c++) begin
         #1;
         total++;
         if ({o_m0_arready, o_s_arvalid} !== 2'b00) begin bad++; $display("FAIL max_block%0d got=%b exp=00", c, {o_m0_arready, o_s_arvalid}); end
         @(negedge clk);
      end
      i_s_rid = 5'h01; i_s_rlast = 1'b1; i_s_rvalid = 1'b1;
      #1;
      total++;
      if ({o_m0_rvalid, o_m0_arready} !== 2'b10) begin bad++; $display("FAIL max_rbeat got=%b exp=10", {o_m0_rvalid, o_m0_arready}); end
      @(negedge clk);
      i_s_rvalid = 1'b0; i_s_rlast = 1'b0;
      #1;
      total++;
      if (o_m0_arready !== 1'b1) begin bad++; $display("FAIL max_regrant got=%b exp=1", o_m0_arready); end
      @(negedge clk);
      @(negedge clk);
      i_m0_arvalid = 1'b0;
      for (int k = 0; k < 4; k++) r_beat(5'h01, 1'b1);
   endtask

   // Slave stalls arready for 5 cycles: AR outputs hold, no new grants.
   task automatic test_stall();
      i_m0_arid = 4'h5; i_m0_araddr = 32'hABCD_0000; i_m0_arlen = 8'h07;
      i_m0_arsize = 3'h3; i_m0_arburst = 2'h1;
      i_s_arready  = 1'b0;
      i_m0_arvalid = 1'b1;
      @(negedge clk);
      i_m0_araddr  = 32'h1111_1111;
      i_m1_arvalid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         total++;
         if ({o_s_arvalid, o_s_arid, o_s_araddr, o_s_arlen, o_s_arsize, o_s_arburst} !==
             {1'b1, 5'h05, 32'hABCD_0000, 8'h07, 3'h3, 2'h1}) begin
            bad++; $display("FAIL stall_hold%0d got=%b %h %h %h", c, o_s_arvalid, o_s_arid, o_s_araddr, o_s_arlen);
         end
         total++;
         if ({o_m0_arready, o_m1_arready} !== 2'b00) begin bad++; $display("FAIL stall_ready%0d got=%b exp=00", c, {o_m0_arready, o_m1_arready}); end
         @(negedge clk);
      end
      i_s_arready = 1'b1;
      @(negedge clk);
      i_m0_arvalid = 1'b0;
      i_m1_arvalid = 1'b0;
      r_beat(5'h05, 1'b1);
   endtask

   // Combinational R steering toward m1 with m1 not ready.
   task automatic test_r_route();
      i_m1_rready = 1'b0;
      i_s_rdata   = 64'hDEAD_BEEF_0123_4567;
      i_s_rresp   = 2'b10;
      i_s_rlast   = 1'b1;
      i_s_rid     = 5'h13;
      i_s_rvalid  = 1'b1;
      #1;
      total++;
      if ({o_m1_rvalid, o_m1_rid, o_m0_rvalid, o_s_rready} !== {1'b1, 4'h3, 1'b0, 1'b0}) begin
         bad++; $display("FAIL route_m1 got=%b %h %b %b exp=1 3 0 0", o_m1_rvalid, o_m1_rid, o_m0_rvalid, o_s_rready);
      end
      total++;
      if ({o_m0_rdata, o_m1_rdata, o_m0_rresp, o_m1_rlast} !== {64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 2'b10, 1'b1}) begin
         bad++; $display("FAIL route_data got=%h %h %b %b", o_m0_rdata, o_m1_rdata, o_m0_rresp, o_m1_rlast);
      end
      @(negedge clk);
      i_s_rvalid  = 1'b0;
      i_s_rlast   = 1'b0;
      i_m1_rready = 1'b1;
      #1;
      total++;
      if (o_err !== 1'b0) begin bad++; $display("FAIL route_noerr got=%b exp=0", o_err); end
   endtask

   // R beat for m1 with nothing outstanding: sticky error, no underflow.
   task automatic test_err();
      i_s_rid = 5'h10; i_s_rlast = 1'b1; i_s_rvalid = 1'b1;
      #1;
      total++;
      if ({o_m1_rvalid, o_s_rready} !== 2'b11) begin bad++; $display("FAIL err_fwd got=%b exp=11", {o_m1_rvalid, o_s_rready}); end
      @(negedge clk);
      i_s_rvalid = 1'b0; i_s_rlast = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++;
      if ({o_err, dut.u_cnt_m1.count_r} !== {1'b1, 3'd0}) begin bad++; $display("FAIL err_sticky got=%b/%0d exp=1/0", o_err, dut.u_cnt_m1.count_r); end
   endtask

   // Same-cycle AR handshake and final beat for m0 at count 2; reset mid-PEND.
   task automatic test_simul_and_reset();
      i_m0_arid = 4'h0; i_m0_araddr = 32'h0000_3000;
      i_s_arready  = 1'b1;
      i_m0_arvalid = 1'b1;
      repeat (4) @(negedge clk);
      i_s_arready = 1'b0;
      @(negedge clk);
      total++;
      if ({o_s_arvalid, dut.u_cnt_m0.count_r} !== {1'b1, 3'd2}) begin bad++; $display("FAIL simul_pre got=%b/%0d exp=1/2", o_s_arvalid, dut.u_cnt_m0.count_r); end
      i_s_arready = 1'b1;
      i_s_rid = 5'h00; i_s_rlast = 1'b1; i_s_rvalid = 1'b1;
      @(negedge clk);
      i_s_rvalid = 1'b0; i_s_rlast = 1'b0; i_s_arready = 1'b0;
      #1;
      total++;
      if (dut.u_cnt_m0.count_r !== 3'd2) begin bad++; $display("FAIL simul_cnt got=%0d exp=2", dut.u_cnt_m0.count_r); end
      @(negedge clk);
      total++;
      if (o_s_arvalid !== 1'b1) begin bad++; $display("FAIL simul_pend got=%b exp=1", o_s_arvalid); end
      rst = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if ({o_s_arvalid, o_m0_arready, o_err, dut.u_cnt_m0.count_r, dut.u_cnt_m1.count_r, o_s_araddr} !== 41'd0) begin
         bad++; $display("FAIL midrst got=%b %b %b %0d %0d %h", o_s_arvalid, o_m0_arready, o_err, dut.u_cnt_m0.count_r, dut.u_cnt_m1.count_r, o_s_araddr);
      end
      i_m0_arvalid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      i_m1_rready = 1'b0;
      i_s_rid = 5'h11; i_s_rvalid = 1'b1;
      #1;
      total++;
      if ({o_m1_rvalid, o_m0_rvalid, o_m1_rid} !== {1'b1, 1'b0, 4'h1}) begin bad++; $display("FAIL post_rst_route got=%b %b %h", o_m1_rvalid, o_m0_rvalid, o_m1_rid); end
      @(negedge clk);
      i_s_rvalid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      i_m0_arvalid = 1'b0; i_m1_arvalid = 1'b0;
      i_m0_arid = 4'h0; i_m1_arid = 4'h0;
      i_m0_araddr = 32'd0; i_m1_araddr = 32'd0;
      i_m0_arlen = 8'd0; i_m1_arlen = 8'd0;
      i_m0_arsize = 3'd0; i_m1_arsize = 3'd0;
      i_m0_arburst = 2'd0; i_m1_arburst = 2'd0;
      i_m0_rready = 1'b1; i_m1_rready = 1'b1;
      i_s_arready = 1'b0; i_s_rvalid = 1'b0;
      i_s_rid = 5'h00; i_s_rdata = 64'd0; i_s_rresp = 2'd0; i_s_rlast = 1'b0;
      @(negedge clk);
      test_reset();
      test_round_robin();
      test_max_out();
      test_stall();
      test_r_route();
      test_err();
      test_simul_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_axi_rd_arbiter

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, meaning per-master AXI ID width; slave-side ID is ID_WIDTH+1.
REQ-002 SHALL have parameter MAX_OUT, default 4, meaning maximum outstanding read bursts per master (range 1..15).
REQ-003 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports i_mN_arvalid / o_mN_arready (N=0,1)  in/out  1/1  master N read-address handshake.
REQ-006 SHALL have ports i_mN_arid / araddr / arlen / arsize / arburst  in  ID_WIDTH/32/8/3/2  master N read-address fields.
REQ-007 SHALL have ports o_mN_rvalid / i_mN_rready  out/in  1/1  master N read-data handshake.
REQ-008 SHALL have ports o_mN_rid / rdata / rresp / rlast  out  ID_WIDTH/64/2/1  master N read-data fields.
REQ-009 SHALL have ports o_s_arvalid / i_s_arready  out/in  1/1  shared slave read-address handshake.
REQ-010 SHALL have ports o_s_arid / araddr / arlen / arsize / arburst  out  ID_WIDTH+1/32/8/3/2  slave read-address fields.
REQ-011 SHALL have ports i_s_rvalid / o_s_rready  in/out  1/1  slave read-data handshake.
REQ-012 SHALL have ports i_s_rid / rdata / rresp / rlast  in  ID_WIDTH+1/64/2/1  slave read-data fields.
REQ-013 SHALL have port o_err  out  1  sticky flag: R beat received for a master with zero outstanding bursts.

Function
REQ-014 SHALL implement a two-state AR FSM: IDLE (o_s_arvalid=0) and PEND (o_s_arvalid=1).
REQ-015 In IDLE, a master is eligible iff its arvalid=1 and its outstanding count < MAX_OUT.
REQ-016 In IDLE with >=1 eligible master, SHALL grant one, register its AR fields into the slave AR register, pulse its o_mN_arready for exactly that cycle, and enter PEND next cycle.
REQ-017 Arbitration SHALL be round-robin: if both eligible, grant the master not granted last; after reset m0 has priority.
REQ-018 o_s_arid SHALL equal {granted master index, master arid}; index in bit ID_WIDTH.
REQ-019 In PEND, o_s_ar* SHALL stay stable until i_s_arready=1; on that handshake return to IDLE (one idle cycle between AR issues, no same-cycle regrant).
REQ-020 Per-master outstanding counter SHALL increment on slave AR handshake for that master and decrement on slave R handshake with rlast=1 and i_s_rid[ID_WIDTH] selecting that master; simultaneous inc and dec SHALL leave it unchanged.
REQ-021 R routing SHALL be combinational on i_s_rid[ID_WIDTH]: selected o_mN_rvalid=i_s_rvalid, other o_mN_rvalid=0, o_s_rready=selected i_mN_rready, o_mN_rid=i_s_rid[ID_WIDTH-1:0], rdata/rresp/rlast passed unchanged to both masters.
REQ-022 R beats SHALL be forwarded independently of AR FSM state; AR and R paths never stall each other except via REQ-015.
REQ-023 An R handshake for a master whose counter is 0 SHALL set o_err, be forwarded, and leave counter at 0 (no underflow).
REQ-024 Counter SHALL never exceed MAX_OUT; width ceil(log2(MAX_OUT+1)).

Reset
REQ-025 On rst: FSM=IDLE, o_s_arvalid=0, o_m0_arready=o_m1_arready=0, both counters=0, RR priority=m0, o_err=0, slave AR register=0.
REQ-026 Reset mid-burst SHALL abandon all tracking; combinational R outputs follow inputs immediately after reset.

Structure
REQ-027 FSM state encoding and master-index constants SHALL live in a shared package axi_arb_pkg.
REQ-028 The per-master outstanding counter SHALL be one sub-module, axi_arb_outcnt, instantiated twice.

Verification
REQ-029 Both arvalid=1 after reset, arready always 1 -> grants m0, m1, m0, m1; o_s_arid[ID_WIDTH]=0,1,0,1; AR issues every 2 cycles.
REQ-030 m0 issues 4 ARs (MAX_OUT=4), no R returned -> fifth m0 request not granted; after one R with rlast, rid MSB=0, m0 granted next IDLE cycle.
REQ-031 i_s_arready held 0 for 5 cycles in PEND -> o_s_araddr/arid stable all 5 cycles, no new master arready pulses.
REQ-032 i_s_rid=5'h13, i_s_rvalid=1, i_m1_rready=0 -> o_m1_rvalid=1, o_m1_rid=4'h3, o_m0_rvalid=0, o_s_rready=0.
REQ-033 R beat with rid MSB=1 while m1 count=0 -> o_err=1 and stays 1 until rst; counter stays 0.
REQ-034 Same-cycle slave AR handshake and final R beat for m0 with count=2 -> count remains 2; rst asserted mid-PEND -> o_s_arvalid=0 next cycle, counters 0.
